// File: rtl/hamming_ext_pkg.sv
// -----------------------------------------------------------------------------
// hamming_ext_pkg
// Shared types and constants for the extended Hamming (8,4) SECDED decoder.
//
// Codeword layout, bit7..bit0: {p4, d4, d3, d2, p3, d1, p2, p1}
//   - p1/p2/p3 are the classic Hamming(7,4) check bits at positions 1, 2, 4
//     (1-based), so a non-zero syndrome S names the failing bit as bit S-1.
//   - p4 is the overall parity bit that turns SEC into SECDED.
// -----------------------------------------------------------------------------
package hamming_ext_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,   // clean word
        ERR_CORR   = 2'b01,   // single error in bits 0..6, corrected
        ERR_P4     = 2'b10,   // single error in the overall parity bit only
        ERR_DOUBLE = 2'b11    // double error, data passed through raw
    } err_status_e;

    localparam int P1_POS = 0;
    localparam int P2_POS = 1;
    localparam int D1_POS = 2;
    localparam int P3_POS = 3;
    localparam int D2_POS = 4;
    localparam int D3_POS = 5;
    localparam int D4_POS = 6;
    localparam int P4_POS = 7;

    // Pull the four data bits out of a codeword as {d4, d3, d2, d1}.
    function automatic logic [3:0] extract_data(input logic [7:0] codeword);
        return {codeword[D4_POS], codeword[D3_POS], codeword[D2_POS], codeword[D1_POS]};
    endfunction

endpackage

// File: rtl/hamming_syndrome_ext.sv
// -----------------------------------------------------------------------------
// hamming_syndrome_ext
// Purely combinational syndrome / overall-parity generator for the extended
// Hamming (8,4) codeword. Has no state, so any checker can reuse it.
//
// Ports:
//   codeword  in  8  {p4,d4,d3,d2,p3,d1,p2,p1}
//   syndrome  out 3  {s3,s2,s1}; non-zero value S points at bit S-1
//   parity    out 1  XOR of all eight bits (1 = odd number of flips)
// -----------------------------------------------------------------------------
module hamming_syndrome_ext
    import hamming_ext_pkg::*;
(
    input  logic [7:0] codeword,
    output logic [2:0] syndrome,
    output logic       parity
);

    logic s1;
    logic s2;
    logic s3;

    assign s1 = codeword[P1_POS] ^ codeword[D1_POS] ^ codeword[D2_POS] ^ codeword[D4_POS];
    assign s2 = codeword[P2_POS] ^ codeword[D1_POS] ^ codeword[D3_POS] ^ codeword[D4_POS];
    assign s3 = codeword[P3_POS] ^ codeword[D2_POS] ^ codeword[D3_POS] ^ codeword[D4_POS];

    assign syndrome = {s3, s2, s1};

    // Written out per position rather than as a reduction so the bit map
    // in the package remains the single source of truth for the layout.
    assign parity = codeword[P1_POS] ^ codeword[P2_POS] ^ codeword[D1_POS] ^ codeword[P3_POS]
                  ^ codeword[D2_POS] ^ codeword[D3_POS] ^ codeword[D4_POS] ^ codeword[P4_POS];

endmodule

// File: rtl/hamming_decoder_ext.sv
// -----------------------------------------------------------------------------
// hamming_decoder_ext
// Two-stage pipelined SECDED decoder for extended Hamming (8,4) codewords,
// with saturating health counters for corrected and uncorrectable words.
//
// Parameters:
//   CNT_W            width of each error counter (>= 2)
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous, active-high reset
//   in_valid         codeword valid
//   in_ready         decoder can take a codeword this cycle
//   in_codeword[8]   {p4,d4,d3,d2,p3,d1,p2,p1}
//   out_valid        decoded result valid
//   out_ready        downstream accepts the result
//   out_data[4]      {d4,d3,d2,d1}, corrected where possible
//   out_status[2]    00 clean, 01 corrected, 10 p4-only error, 11 double error
//   out_syndrome[3]  {s3,s2,s1}, debug visibility
//   cnt_clr          synchronous clear of both counters (wins over increment)
//   corr_cnt         output-handshaked words with status 01 or 10
//   uncorr_cnt       output-handshaked words with status 11
//
// Optional build macro HAMMING_DEC_ERR_LOG_EN adds:
//   err_log_valid        a double-error codeword has been captured
//   err_log_codeword[8]  raw codeword of the first double error seen
//                        downstream since reset / cnt_clr (sticky)
//
// Pipeline: S1 holds the raw codeword, S2 holds the decoded result. Decode
// is combinational between them. A stage loads when it is empty or when
// its downstream is taking its current contents this cycle.
// -----------------------------------------------------------------------------
module hamming_decoder_ext
    import hamming_ext_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_codeword,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [1:0]       out_status,
    output logic [2:0]       out_syndrome,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
`ifdef HAMMING_DEC_ERR_LOG_EN
    ,
    output logic             err_log_valid,
    output logic [7:0]       err_log_codeword
`endif
);

    // ---------------------------------------------------------------------
    // Pipeline state
    // ---------------------------------------------------------------------
    logic        s1_valid;
    logic [7:0]  s1_codeword;

    logic        s2_valid;
    logic [3:0]  s2_data;
    err_status_e s2_status;
    logic [2:0]  s2_syndrome;
`ifdef HAMMING_DEC_ERR_LOG_EN
    logic [7:0]  s2_raw;
`endif

    logic in_fire;
    logic out_fire;
    logic s2_load;
    logic s1_advance;

    assign out_fire   = s2_valid && out_ready;
    // S2 can take a new word when empty or when its word leaves this cycle.
    assign s2_load    = !s2_valid || out_ready;
    assign s1_advance = s1_valid && s2_load;
    assign in_ready   = !s1_valid || s1_advance;
    assign in_fire    = in_valid && in_ready;

    // ---------------------------------------------------------------------
    // Decode between S1 and S2
    // ---------------------------------------------------------------------
    logic [2:0]  dec_syndrome;
    logic        dec_parity;
    logic [7:0]  flip_mask;
    logic [7:0]  dec_codeword;
    err_status_e dec_status;

    hamming_syndrome_ext u_syndrome (
        .codeword (s1_codeword),
        .syndrome (dec_syndrome),
        .parity   (dec_parity)
    );

    always_comb begin
        flip_mask    = 8'h00;
        dec_status   = ERR_NONE;
        if (dec_syndrome == 3'd0) begin
            // Zero syndrome with odd parity means only p4 flipped; the data
            // bits are untouched.
            if (dec_parity) begin
                dec_status = ERR_P4;
            end
        end else if (dec_parity) begin
            flip_mask  = 8'(1) << (dec_syndrome - 3'd1);
            dec_status = ERR_CORR;
        end else begin
            // Even parity with a non-zero syndrome: two bits flipped. Do not
            // "correct" -- that would corrupt a third bit.
            dec_status = ERR_DOUBLE;
        end
        dec_codeword = s1_codeword ^ flip_mask;
    end

    // ---------------------------------------------------------------------
    // Stage 1: raw codeword register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_codeword <= 8'h00;
        end else begin
            if (in_fire) begin
                s1_valid    <= 1'b1;
                s1_codeword <= in_codeword;
            end else if (s1_advance) begin
                s1_valid    <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: decoded result register (also the output register, so the
    // outputs are held naturally while out_ready is low)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            s2_data     <= 4'h0;
            s2_status   <= ERR_NONE;
            s2_syndrome <= 3'd0;
`ifdef HAMMING_DEC_ERR_LOG_EN
            s2_raw      <= 8'h00;
`endif
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data     <= extract_data(dec_codeword);
                s2_status   <= dec_status;
                s2_syndrome <= dec_syndrome;
`ifdef HAMMING_DEC_ERR_LOG_EN
                s2_raw      <= s1_codeword;
`endif
            end
        end
    end

    assign out_valid    = s2_valid;
    assign out_data     = s2_data;
    assign out_status   = s2_status;
    assign out_syndrome = s2_syndrome;

    // ---------------------------------------------------------------------
    // Health counters: counted only on the output handshake so a word held
    // under backpressure is never counted twice.
    // ---------------------------------------------------------------------
    logic is_corr;
    logic is_double;

    assign is_corr   = out_fire && ((s2_status == ERR_CORR) || (s2_status == ERR_P4));
    assign is_double = out_fire && (s2_status == ERR_DOUBLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (is_corr && (corr_cnt != '1)) begin
                corr_cnt <= corr_cnt + CNT_W'(1);
            end
            if (is_double && (uncorr_cnt != '1)) begin
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            end
        end
    end

`ifdef HAMMING_DEC_ERR_LOG_EN
    // First double-error codeword is sticky until cnt_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_log_valid    <= 1'b0;
            err_log_codeword <= 8'h00;
        end else if (cnt_clr) begin
            err_log_valid    <= 1'b0;
            err_log_codeword <= 8'h00;
        end else if (is_double && !err_log_valid) begin
            err_log_valid    <= 1'b1;
            err_log_codeword <= s2_raw;
        end
    end
`endif

endmodule

// File: tb/tb_hamming_decoder_ext.sv
module tb_hamming_decoder_ext;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_codeword;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic [1:0]       out_status;
    logic [2:0]       out_syndrome;
    logic             cnt_clr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;
`ifdef HAMMING_DEC_ERR_LOG_EN
    logic             err_log_valid;
    logic [7:0]       err_log_codeword;
`endif

    hamming_decoder_ext #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_codeword  (in_codeword),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_status   (out_status),
        .out_syndrome (out_syndrome),
        .cnt_clr      (cnt_clr),
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt)
`ifdef HAMMING_DEC_ERR_LOG_EN
        ,
        .err_log_valid    (err_log_valid),
        .err_log_codeword (err_log_codeword)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int fails  = 0;

    // expected entry: {data[3:0], status[1:0], syndrome[2:0]}
    logic [8:0] sb_q[$];

    function automatic logic [8:0] ex(input logic [3:0] d, input logic [1:0] st, input logic [2:0] sy);
        return {d, st, sy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL out_unexpected: got data=%0h status=%0h syn=%0h expected no output",
                         out_data, out_status, out_syndrome);
            end else begin
                logic [8:0] e;
                e = sb_q.pop_front();
                if ({out_data, out_status, out_syndrome} !== e) begin
                    fails++;
                    $display("FAIL out_word: got data=%0h status=%0h syn=%0h expected data=%0h status=%0h syn=%0h",
                             out_data, out_status, out_syndrome, e[8:5], e[4:3], e[2:0]);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] cw, input logic [8:0] e);
        bit ok;
        ok = 0;
        in_valid    = 1'b1;
        in_codeword = cw;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(e);
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        if (!ok) check("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_codeword = 8'h00;
        out_ready   = 1'b0;
        cnt_clr     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",   32'(in_ready), 32'd1);
        check("rst_out_valid",  32'(out_valid), 32'd0);
        check("rst_out_fields", 32'({out_data, out_status, out_syndrome}), 32'd0);
        check("rst_counters",   32'({corr_cnt, uncorr_cnt}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // clean word
        send(8'h55, ex(4'hB, 2'b00, 3'b000));
        drain();
        check("clean_corr_cnt",   32'(corr_cnt), 32'd0);
        check("clean_uncorr_cnt", 32'(uncorr_cnt), 32'd0);

        // single error in d1 (bit2)
        send(8'h51, ex(4'hB, 2'b01, 3'b011));
        drain();
        check("single_corr_cnt", 32'(corr_cnt), 32'd1);

        // single error in p4 (bit7)
        send(8'hD5, ex(4'hB, 2'b10, 3'b000));
        drain();
        check("p4_corr_cnt", 32'(corr_cnt), 32'd2);

        // double errors
        send(8'h56, ex(4'hB, 2'b11, 3'b011));
        drain();
        check("double_uncorr_cnt", 32'(uncorr_cnt), 32'd1);
`ifdef HAMMING_DEC_ERR_LOG_EN
        check("log_valid",    32'(err_log_valid), 32'd1);
        check("log_codeword", 32'(err_log_codeword), 32'h56);
`endif
        send(8'h03, ex(4'h0, 2'b11, 3'b011));
        drain();
        check("double2_uncorr_cnt", 32'(uncorr_cnt), 32'd2);
        check("double2_corr_cnt",   32'(corr_cnt), 32'd2);
`ifdef HAMMING_DEC_ERR_LOG_EN
        check("log_sticky", 32'(err_log_codeword), 32'h56);
`endif

        // backpressure: two words held, third stalls at the input
        out_ready = 1'b0;
        send(8'h00, ex(4'h0, 2'b00, 3'b000));
        send(8'h55, ex(4'hB, 2'b00, 3'b000));
        in_valid    = 1'b1;
        in_codeword = 8'hFF;
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_held",     32'({out_valid, out_data}), 32'h10);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'hFF, ex(4'hF, 2'b00, 3'b000));
        drain();
        check("bp_counts", 32'({corr_cnt, uncorr_cnt}), 32'({4'd2, 4'd2}));

        // saturation: 20 back-to-back corrected words
        for (int i = 0; i < 20; i++) send(8'h51, ex(4'hB, 2'b01, 3'b011));
        drain();
        check("sat_corr_cnt", 32'(corr_cnt), 32'd15);

        // clear coincident with a corrected-word handshake
        out_ready = 1'b0;
        send(8'h51, ex(4'hB, 2'b01, 3'b011));
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        check("clr_word_present", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(posedge clk); #1;
        cnt_clr   = 1'b0;
        check("clr_corr_cnt",   32'(corr_cnt), 32'd0);
        check("clr_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
`ifdef HAMMING_DEC_ERR_LOG_EN
        check("clr_log_valid", 32'(err_log_valid), 32'd0);
`endif
        send(8'h03, ex(4'h0, 2'b11, 3'b011));
        drain();
        check("post_clr_uncorr", 32'(uncorr_cnt), 32'd1);
`ifdef HAMMING_DEC_ERR_LOG_EN
        check("post_clr_log", 32'(err_log_codeword), 32'h03);
`endif

        // asynchronous reset with two words in flight
        out_ready = 1'b0;
        send(8'h00, ex(4'h0, 2'b00, 3'b000));
        send(8'h55, ex(4'hB, 2'b00, 3'b000));
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_counters",  32'({corr_cnt, uncorr_cnt}), 32'd0);
        check("arst_in_ready",  32'(in_ready), 32'd1);
        sb_q.delete();
        @(negedge clk); #2;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("arst_no_stale", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        send(8'hD5, ex(4'hB, 2'b10, 3'b000));
        drain();
        check("arst_resume_corr", 32'(corr_cnt), 32'd1);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule

// File: doc/hamming_decoder_ext.md
Name: hamming_decoder_ext

Overview:
- Pipelined SECDED decoder for the extended Hamming (8,4) codeword produced by the encoder stage. Sits directly downstream of it.
- Accepts one 8-bit codeword per valid/ready handshake and returns 4-bit data with a correction/detection status.
- Keeps saturating counts of corrected and uncorrectable words for system health monitoring.

Parameters:
- CNT_W, 16, width of each error counter (≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  codeword valid
- in_ready  out  1  decoder can accept a codeword this cycle
- in_codeword  in  8  {p4,d4,d3,d2,p3,d1,p2,p1}, bit7..bit0
- out_valid  out  1  decoded result valid
- out_ready  in  1  downstream accepts result
- out_data  out  4  {d4,d3,d2,d1}, corrected where possible
- out_status  out  2  00 clean, 01 single error corrected (bits 0–6), 10 single error in p4 only, 11 double error detected
- out_syndrome  out  3  {s3,s2,s1}, for debug
- cnt_clr  in  1  synchronous clear of both counters
- corr_cnt  out  CNT_W  words accepted downstream with status 01 or 10
- uncorr_cnt  out  CNT_W  words accepted downstream with status 11

Behaviour:
- Reset values: in_ready=1; out_valid=0; out_data, out_status and out_syndrome=0; both counters=0.
- Reset asserted mid-operation discards all in-flight words.
- Handshake:
  - Transfer occurs when valid and ready are both high.
  - out_valid/out_data/out_status are held stable while out_valid=1 and out_ready=0.
- Pipeline, two stages, latency 2 cycles from input handshake to out_valid:
  - S1 registers the codeword.
  - S2 registers the decoded result.
  - Each stage advances when it is empty or its downstream stage advances this cycle.
  - in_ready = !s1_valid || s1_advance, so throughput is 1 word/cycle with out_ready=1.
- Under out_ready=0, two words are held and in_ready drops. No word is lost or duplicated.
- Decode (combinational in S1→S2):
  - s1 = b0^b2^b4^b6
  - s2 = b1^b2^b5^b6
  - s3 = b3^b4^b5^b6
  - P = XOR of b7..b0
  - S={s3,s2,s1}
- Decision table:
  - S=0, P=0: status 00.
  - S=0, P=1: status 10; data bits are unaffected.
  - S≠0, P=1: flip bit S-1, status 01.
  - S≠0, P=0: status 11; out_data carries the raw, uncorrected data bits.
- Counters:
  - Increment on the output handshake only, so each word is counted exactly once.
  - Saturate at 2^CNT_W-1 and never wrap.
  - cnt_clr has priority over an increment in the same cycle; that word is not counted.

Optional Feature:
- Macro: HAMMING_DEC_ERR_LOG_EN.
- When defined:
  - Adds outputs err_log_valid (1) and err_log_codeword (8).
  - The raw codeword of the first status-11 word accepted downstream is captured.
  - The capture is sticky and ignores later double errors until cnt_clr.
  - Reset value 0.
- When undefined: these ports and their registers do not exist. All other behaviour is identical.

Decomposition:
- Package hamming_ext_pkg:
  - Typedef err_status_e {ERR_NONE=2'b00, ERR_CORR=2'b01, ERR_P4=2'b10, ERR_DOUBLE=2'b11}.
  - Localparams for codeword bit positions (P1_POS=0, P2_POS=1, D1_POS=2, P3_POS=3, D2_POS=4, D3_POS=5, D4_POS=6, P4_POS=7).
- Sub-module hamming_syndrome_ext: purely combinational, 8-bit codeword → {syndrome[2:0], overall_parity}. Reusable by other checkers in the codebase.

Test Plan:
- Clean word: data 4'hB, in_codeword 8'h55, out_ready=1 → 2 cycles later out_data=4'hB, status 00, syndrome 000, counters unchanged.
- Single error:
  - 8'h51 (bit2 flipped) → out_data 4'hB, status 01, syndrome 011, corr_cnt=1.
  - 8'hD5 (bit7 flipped) → out_data 4'hB, status 10, syndrome 000, corr_cnt=2.
- Double error: 8'h56 (bits 0,1 flipped) → status 11, syndrome 011, out_data 4'hB (raw bits), uncorr_cnt=1. With HAMMING_DEC_ERR_LOG_EN: err_log_valid=1, err_log_codeword=8'h56; a second double error leaves the log at 8'h56.
- Backpressure:
  - out_ready=0; drive 8'h00, 8'h55, 8'hFF back-to-back → in_ready falls after 2 accepts; third word held at input.
  - Release out_ready → outputs 4'h0, 4'hB, 4'hF in order, each status 00, no duplicates.
- Counter saturation and clear:
  - CNT_W=4, 20 single-error words → corr_cnt=15.
  - Assert cnt_clr in the same cycle as a corrected-word handshake → corr_cnt=0 next cycle.
- Reset mid-flight: 2 words in pipeline, pulse rst asynchronously between edges → out_valid=0 and counters=0 immediately; no stale output after release.
